// File: rtl/addsub_pkg.sv
// Shared sizing and state encoding for the chunk-serial adder/subtractor.
package addsub_pkg;
    localparam int ADD_WIDTH = 32;
    localparam int CHUNK_W   = 8;
    localparam int N_CHUNKS  = ADD_WIDTH / CHUNK_W;
    localparam int CNT_W     = $clog2(N_CHUNKS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;
endpackage

// File: rtl/addsub_slice_8b.sv
// One 8-bit add slice; cin enters as bit-0 generate so the tree needs no separate carry input.
module addsub_slice_8b (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout,
    output logic       c6
);
    logic [7:0] p, g, g_f, c;

    assign p   = a ^ b;
    assign g   = a & b;
    assign g_f = {g[7:1], g[0] | (p[0] & cin)};

    carry_tree_bk_8b u_tree (
        .g (g_f),
        .p (p[7:1]),
        .c (c)
    );

    assign s    = p ^ {c[6:0], cin};
    assign cout = c[7];
    assign c6   = c[6];
endmodule

// File: rtl/carry_tree_bk_8b.sv
// 8-bit Brent-Kung carry prefix tree. c[i] is the carry out of bit i.
// Bit 0 propagate is not needed because any carry-in is already folded into g[0].
module carry_tree_bk_8b (
    input  logic [7:0] g,
    input  logic [7:1] p,
    output logic [7:0] c
);
    logic g10, g32, p32, g54, p54, g76, p76;
    logic g30, g74, p74, g70;
    logic g20, g40, g50, g60;

    // up-sweep
    assign g10 = g[1] | (p[1] & g[0]);
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g54 = g[5] | (p[5] & g[4]);
    assign p54 = p[5] & p[4];
    assign g76 = g[7] | (p[7] & g[6]);
    assign p76 = p[7] & p[6];
    assign g30 = g32 | (p32 & g10);
    assign g74 = g76 | (p76 & g54);
    assign p74 = p76 & p54;
    assign g70 = g74 | (p74 & g30);

    // down-sweep fills the remaining prefixes
    assign g50 = g54 | (p54 & g30);
    assign g20 = g[2] | (p[2] & g10);
    assign g40 = g[4] | (p[4] & g30);
    assign g60 = g[6] | (p[6] & g50);

    assign c = {g70, g60, g50, g40, g30, g20, g10, g[0]};
endmodule

// File: rtl/addsub_iter_32b.sv
// Chunk-serial WIDTH-bit adder/subtractor: one CHUNK per cycle, LSB first, valid/ready both sides.
module addsub_iter_32b
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int CHUNK = CHUNK_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             zero_o
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
    logic             c_q, carry_q, ovf_q, zero_q;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] s;
    logic             cout, c6, last;

    // Operands shift right each cycle so the active chunk is always at the bottom;
    // the result fills from the top and is complete after NCH shifts.
    addsub_slice_8b u_slice (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .cin  (c_q),
        .s    (s),
        .cout (cout),
        .c6   (c6)
    );

    assign last    = (cnt == CW'(NCH - 1));
    assign res_nxt = {s, res_q[WIDTH-1:CHUNK]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid_i)  state_nxt = ST_BUSY;
            ST_BUSY: if (last)        state_nxt = ST_DONE;
            ST_DONE: if (out_ready_i) state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid_i) begin
                    a_q <= a_i;
                    b_q <= b_i ^ {WIDTH{sub_i}};
                    c_q <= sub_i;
                    cnt <= '0;
                end
                ST_BUSY: begin
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    res_q <= res_nxt;
                    c_q   <= cout;
                    cnt   <= cnt + CW'(1);
                    // top chunk: carry into the MSB vs carry out of it gives signed overflow
                    if (last) begin
                        carry_q <= cout;
                        ovf_q   <= c6 ^ cout;
                        zero_q  <= (res_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (state == ST_IDLE);
    assign out_valid_o = (state == ST_DONE);
    assign sum_o       = res_q;
    assign carry_o     = carry_q;
    assign ovf_o       = ovf_q;
    assign zero_o      = zero_q;
endmodule

// File: tb/tb_addsub_iter_32b.sv
// Bench for addsub_iter_32b: directed corner cases plus random ops against an arithmetic model.
module tb_addsub_iter_32b;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        sub_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] sum_o;
    logic        carry_o, ovf_o, zero_o;

    int n_vec = 0;
    int n_err = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    addsub_iter_32b dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .sub_i       (sub_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .carry_o     (carry_o),
        .ovf_o       (ovf_o),
        .zero_o      (zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Reference is plain integer arithmetic; operands on the pins are scrambled after accept.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
        logic [31:0] es;
        logic        ec, eo, ez;
        longint      sa, sb, r;
        int          lat;
        es = s ? a - b : a + b;
        ec = s ? (a >= b) : ((64'(a) + 64'(b)) > 64'hFFFF_FFFF);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = s ? sa - sb : sa + sb;
        eo = (r > SMAX) || (r < SMIN);
        ez = (es == 32'd0);

        @(negedge clk_i);
        a_i = a; b_i = b; sub_i = s; in_valid_i = 1'b1; out_ready_i = 1'b0;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        a_i = $urandom; b_i = $urandom; sub_i = ~s;
        chk("busy_rdy", 64'(in_ready_o), 64'd0);
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'd4);
        chk("sum", 64'(sum_o), 64'(es));
        chk("carry", 64'(carry_o), 64'(ec));
        chk("ovf", 64'(ovf_o), 64'(eo));
        chk("zero", 64'(zero_o), 64'(ez));
        chk("done_rdy", 64'(in_ready_o), 64'd0);
        for (int i = 0; i < hold; i++) begin
            a_i = $urandom;
            @(posedge clk_i); #1;
            chk("hold_vld", 64'(out_valid_o), 64'd1);
            chk("hold_sum", 64'(sum_o), 64'(es));
            chk("hold_rdy", 64'(in_ready_o), 64'd0);
        end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        chk("drop_vld", 64'(out_valid_o), 64'd0);
        chk("idle_rdy", 64'(in_ready_o), 64'd1);
        chk("keep_sum", 64'(sum_o), 64'(es));
    endtask

    initial begin
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_rdy", 64'(in_ready_o), 64'd1);
        chk("rst_vld", 64'(out_valid_o), 64'd0);
        chk("rst_sum", 64'(sum_o), 64'd0);
        chk("rst_flags", {61'd0, carry_o, ovf_o, zero_o}, 64'd0);
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h0000_0001, 32'h0000_0002, 1'b1, 0);
        run_op(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, 10);

        // reset asserted in the second busy cycle
        @(negedge clk_i);
        a_i = 32'h0F0F_0F0F; b_i = 32'h1111_1111; sub_i = 1'b0; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(out_valid_o), 64'd0);
        chk("mid_rst_rdy", 64'(in_ready_o), 64'd1);
        chk("mid_rst_sum", 64'(sum_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
        chk("no_partial", 64'(out_valid_o), 64'd0);
        run_op(32'd3, 32'd4, 1'b0, 0);

        for (int i = 0; i < 10000; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: ra = {ra[31], {31{~ra[31]}}};
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/addsub_iter_32b.md
Name: addsub_iter_32b

Overview:
- Multi-cycle 32-bit adder/subtractor that processes one 8-bit chunk per cycle, LSB chunk first.
- Each chunk's carries come from the existing carry_tree_bk_8b; the chunk carry-in is folded into bit 0 generate.
- Sits in the datapath wherever area matters more than latency.
- Valid/ready on both sides; produces the full-width result and flags after the last chunk.

Parameters:
- WIDTH, 32, operand width; must be a multiple of CHUNK.
- CHUNK, 8, bits per cycle; fixed to 8 to match carry_tree_bk_8b.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  operands valid.
- in_ready_o  output  1  block can accept operands.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- sub_i  input  1  1 = A-B, 0 = A+B.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- sum_o  output  WIDTH  result.
- carry_o  output  1  unsigned carry out; for sub, 1 = no borrow (A>=B).
- ovf_o  output  1  signed overflow.
- zero_o  output  1  sum_o == 0.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE; in_ready_o=1, out_valid_o=0, sum_o=0, carry_o=0, ovf_o=0, zero_o=0; chunk counter 0.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o, latch a_i, latch b_i^{WIDTH{sub_i}}, set carry register = sub_i, counter=0, go to BUSY.
- BUSY:
  - in_ready_o=0.
  - Each cycle on chunk k = counter: p=a[k]^b'[k], g=a[k]&b'[k], g[0] replaced by g[0]|(p[0]&c).
  - Tree carries c_out[7:0] give sum bit i = p[i]^(i==0 ? c : c_out[i-1]).
  - Write chunk k of the result register; c <= c_out[7].
  - Counter increments. After chunk WIDTH/CHUNK-1 (4th BUSY cycle), go to DONE.
  - For the top chunk, capture the carry into bit 31 for overflow: ovf = c_in_msb ^ c_out_msb.
- DONE:
  - out_valid_o=1; outputs hold stable until out_ready_i=1.
  - zero_o is computed from the full result register.
  - On out_valid_o&&out_ready_i, go to IDLE. out_valid_o drops next cycle; sum/flags keep their last values.
- Latency: accept edge, then 4 BUSY cycles, then out_valid_o high on the 5th edge after acceptance. Throughput is 1 op per 5 cycles minimum plus 1 IDLE cycle (no accept in DONE).
- in_ready_o is combinationally (state==IDLE); it does not depend on out_ready_i.
- No back-to-back accept while DONE. A new in_valid_i during BUSY/DONE is ignored and held by the producer per valid/ready rules.
- Operands are sampled only at acceptance; changes on a_i/b_i/sub_i afterwards have no effect.
- Reset mid-operation: all state is discarded immediately; returns to IDLE with the reset values above, and no partial result is emitted.
- Wrap-around: results are modulo 2^WIDTH; carry_o and ovf_o report the wrap.

Decomposition:
- Shared package addsub_pkg:
  - ADD_WIDTH=32, CHUNK_W=8, N_CHUNKS=ADD_WIDTH/CHUNK_W.
  - State enum {ST_IDLE, ST_BUSY, ST_DONE} (2 bits).
  - Counter width $clog2(N_CHUNKS).
- Sub-module addsub_slice_8b (combinational):
  - Inputs a[7:0], b'[7:0], cin; outputs s[7:0], cout, c6 (carry into bit 7).
  - Instantiates carry_tree_bk_8b.
  - The top-level holds the FSM, operand/result registers and flags.

Test Plan:
- Add: A=0x0000_00FF, B=0x0000_0001, sub=0 → after 5 cycles sum=0x0000_0100, carry=0, ovf=0, zero=0; ripple crosses chunk 0→1.
- Sub equal: A=B=0x1234_5678, sub=1 → sum=0, carry=1, zero=1, ovf=0.
- Signed overflow: A=0x7FFF_FFFF+B=0x0000_0001 → sum=0x8000_0000, ovf=1, carry=0. Also 0x8000_0000-0x0000_0001 → 0x7FFF_FFFF, ovf=1, carry=1.
- Full wrap: A=0xFFFF_FFFF+B=0x0000_0001 → sum=0, carry=1, zero=1, ovf=0. Borrow case 0x0000_0001-0x0000_0002 → 0xFFFF_FFFF, carry=0.
- Backpressure: hold out_ready_i=0 for 10 cycles → out_valid_o and sum stay constant, in_ready_o=0. Raise out_ready_i → IDLE next cycle. Also toggle a_i during BUSY → result unchanged.
- Reset mid-op: assert rst_ni low in the 2nd BUSY cycle → out_valid_o=0, in_ready_o=1 immediately. Next op 3+4 → sum=7 with correct latency. Finally run 10k random add/sub operations against a reference model.
